// File: rtl/fourbyte_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fourbyte_pkg
//  Description : Shared widths and FSM state codes for the 4-byte memory
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fourbyte_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    localparam logic [1:0] ST_SCAN   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fourbyte_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fourbyte_mem_ctrl_if
//  Description : Single-port byte memory bus with 1-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fourbyte_mem_ctrl_if;
    import fourbyte_pkg::*;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (output mem_en, mem_wr, mem_adr, mem_din, input  mem_dout);
    modport slave  (input  mem_en, mem_wr, mem_adr, mem_din, output mem_dout);

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronizes an active-low async button and debounces it;
//                level is 1 while pressed, press_evt pulses on each press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  btn_n_async,
    output logic level,
    output logic press_evt
);

    localparam logic [15:0] c_db_last = 16'(DB_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_press_evt;
    logic [15:0] r_cnt;
    logic        w_sync_pressed;
    logic        w_differs;

    assign w_sync_pressed = ~r_sync2;
    assign w_differs      = (w_sync_pressed != r_level);

    // Counter runs only while the synchronized level disagrees; any agreement restarts it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_level     <= 1'b0;
            r_press_evt <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync1     <= btn_n_async;
            r_sync2     <= r_sync1;
            r_press_evt <= 1'b0;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == c_db_last) begin
                r_cnt       <= '0;
                r_level     <= w_sync_pressed;
                r_press_evt <= w_sync_pressed;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign level     = r_level;
    assign press_evt = r_press_evt;

endmodule
`default_nettype wire

// File: rtl/fourbyte_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fourbyte_mem_ctrl
//  Description : Writes the switch byte on each debounced press, verifies it
//                by readback, and otherwise scans memory to the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module fourbyte_mem_ctrl
    import fourbyte_pkg::*;
#(
    parameter int DB_CYCLES   = 16,
    parameter int SHOW_CYCLES = 32
) (
    input  wire                      clk,
    input  wire                      rst_n,
    input  wire  [DATA_W-1:0]        data_sw,
    input  wire                      wr_bttn,
    fourbyte_mem_ctrl_if.master      mem,
    output logic [DATA_W-1:0]        disp_byte,
    output logic                     disp_valid,
    output logic                     wr_led,
    output logic [ADDR_W-1:0]        adr_led,
    output logic                     err,
    output logic                     busy
);

    localparam int                  c_show_w    = $clog2(SHOW_CYCLES);
    localparam logic [c_show_w-1:0] c_show_last = c_show_w'(SHOW_CYCLES - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_scan_adr;
    logic [ADDR_W-1:0]   w_scan_adr_nxt;
    logic [ADDR_W-1:0]   w_adr_nxt;
    logic [c_show_w-1:0] r_show_cnt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_disp_byte;
    logic                r_disp_valid;
    logic                r_err;
    logic                r_rd_ok;
    logic                r_mem_en;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_adr;
    logic                w_level;
    logic                w_press_evt;
    logic                w_scan_tc;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n_async (wr_bttn),
        .level       (w_level),
        .press_evt   (w_press_evt)
    );

    assign w_scan_tc = (r_show_cnt == c_show_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN:   if (w_press_evt) w_state_nxt = ST_WRITE;
            ST_WRITE:  w_state_nxt = ST_VERIFY;
            ST_VERIFY: w_state_nxt = ST_CHECK;
            default:   w_state_nxt = ST_SCAN;
        endcase
    end

    always_comb begin
        w_scan_adr_nxt = r_scan_adr;
        if (r_state == ST_CHECK) begin
            w_scan_adr_nxt = r_wr_ptr;
        end else if (r_state == ST_SCAN && w_scan_tc) begin
            w_scan_adr_nxt = r_scan_adr + ADDR_W'(1);
        end
    end

    // Bus outputs are registered from the next state so they line up with r_state
    assign w_adr_nxt = (w_state_nxt == ST_SCAN) ? w_scan_adr_nxt : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_SCAN;
            r_wr_ptr     <= '0;
            r_scan_adr   <= '0;
            r_show_cnt   <= '0;
            r_wdata      <= '0;
            r_disp_byte  <= '0;
            r_disp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_adr    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_scan_adr <= w_scan_adr_nxt;
            r_mem_en   <= (w_state_nxt != ST_CHECK);
            r_mem_wr   <= (w_state_nxt == ST_WRITE);
            r_mem_adr  <= w_adr_nxt;
            // Read data is trusted only once the same scan address has been held a full cycle
            r_rd_ok    <= (r_state == ST_SCAN) && r_mem_en && !w_scan_tc && !w_press_evt;
            case (r_state)
                ST_SCAN: begin
                    r_show_cnt <= w_scan_tc ? '0 : r_show_cnt + c_show_w'(1);
                    if (w_press_evt) begin
                        r_wdata <= data_sw;
                    end else if (r_rd_ok) begin
                        r_disp_byte  <= mem.mem_dout;
                        r_disp_valid <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mem.mem_dout != r_wdata) r_err <= 1'b1;
                    r_disp_byte  <= mem.mem_dout;
                    r_disp_valid <= 1'b1;
                    r_show_cnt   <= '0;
                    r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_en  = r_mem_en;
    assign mem.mem_wr  = r_mem_wr;
    assign mem.mem_adr = r_mem_adr;
    assign mem.mem_din = r_wdata;

    assign disp_byte  = r_disp_byte;
    assign disp_valid = r_disp_valid;
    assign wr_led     = ~w_level;
    assign adr_led    = ~r_scan_adr;
    assign err        = r_err;
    assign busy       = (r_state != ST_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_fourbyte_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fourbyte_mem_ctrl
//  Description : Directed self-checking bench with a 4x8 memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fourbyte_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_sw = 8'h00;
    logic       wr_bttn = 1'b1;
    logic [7:0] disp_byte;
    logic       disp_valid;
    logic       wr_led;
    logic [1:0] adr_led;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    fourbyte_mem_ctrl_if mem_if();

    fourbyte_mem_ctrl #(
        .DB_CYCLES   (4),
        .SHOW_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_sw    (data_sw),
        .wr_bttn    (wr_bttn),
        .mem        (mem_if),
        .disp_byte  (disp_byte),
        .disp_valid (disp_valid),
        .wr_led     (wr_led),
        .adr_led    (adr_led),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory model with optional read corruption of address 1
    logic [7:0] mem_arr [4] = '{default: 8'h00};
    logic       corrupt_en = 1'b0;

    always @(posedge clk) begin
        if (mem_if.mem_en) begin
            if (mem_if.mem_wr) mem_arr[mem_if.mem_adr] <= mem_if.mem_din;
            else if (corrupt_en && mem_if.mem_adr == 2'd1) mem_if.mem_dout <= 8'h00;
            else mem_if.mem_dout <= mem_arr[mem_if.mem_adr];
        end
    end

    // Write monitor
    int         wr_cnt = 0;
    logic [1:0] wr_adr_log [32];
    logic [7:0] last_din = 8'h00;

    always @(negedge clk) begin
        if (mem_if.mem_en && mem_if.mem_wr) begin
            wr_adr_log[wr_cnt % 32] <= mem_if.mem_adr;
            last_din                <= mem_if.mem_din;
            wr_cnt                  <= wr_cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wr_bttn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Press and return at the first non-busy cycle after the write sequence
    task automatic press_start(input logic [7:0] d);
        int n;
        data_sw = d;
        wr_bttn = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL press_busy_rise: busy=%b required 1", busy); end
        n = 0;
        while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_fall: busy=%b required 0", busy); end
    endtask

    task automatic release_btn();
        wr_bttn = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        int base;
        @(negedge clk);
        rst_n   = 1'b0;
        wr_bttn = 1'b0;
        data_sw = 8'h3C;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_adr, mem_if.mem_din} !== 12'h000) begin
            errors++;
            $display("FAIL reset_bus: en/wr/adr/din=%h required 000",
                     {mem_if.mem_en, mem_if.mem_wr, mem_if.mem_adr, mem_if.mem_din});
        end
        checks++;
        if ({disp_byte, disp_valid, wr_led, adr_led, err, busy} !== {8'h00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: byte=%h valid=%b wr_led=%b adr_led=%b err=%b busy=%b required 00 0 1 11 0 0",
                     disp_byte, disp_valid, wr_led, adr_led, err, busy);
        end
        base  = wr_cnt;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt !== base) begin errors++; $display("FAIL reset_no_early_write: writes=%0d required 0", wr_cnt - base); end
        checks++;
        if (wr_led !== 1'b1) begin errors++; $display("FAIL reset_led_during_debounce: wr_led=%b required 1", wr_led); end
        repeat (15) @(negedge clk);
        checks++;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL reset_one_write: writes=%0d required 1", wr_cnt - base); end
        checks++;
        if (wr_led !== 1'b0) begin errors++; $display("FAIL reset_led_pressed: wr_led=%b required 0", wr_led); end
        release_btn();
    endtask

    task automatic test_single_write();
        int base;
        do_reset();
        base = wr_cnt;
        press_start(8'hA5);
        checks++;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL single_count: writes=%0d required 1", wr_cnt - base); end
        checks++;
        if (wr_adr_log[base % 32] !== 2'd0) begin errors++; $display("FAIL single_adr: adr=%0d required 0", wr_adr_log[base % 32]); end
        checks++;
        if (last_din !== 8'hA5) begin errors++; $display("FAIL single_din: din=%h required a5", last_din); end
        checks++;
        if ({err, disp_valid, disp_byte, adr_led} !== {1'b0, 1'b1, 8'hA5, 2'b11}) begin
            errors++;
            $display("FAIL single_display: err=%b valid=%b byte=%h adr_led=%b required 0 1 a5 11",
                     err, disp_valid, disp_byte, adr_led);
        end
        release_btn();
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            wr_bttn = (i % 2 == 1);
            repeat (2) @(negedge clk);
            checks++;
            if (wr_led !== 1'b1) begin errors++; $display("FAIL bounce_led_phase%0d: wr_led=%b required 1", i, wr_led); end
        end
        wr_bttn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_led !== 1'b1) begin errors++; $display("FAIL bounce_led_early: wr_led=%b required 1", wr_led); end
        @(negedge clk);
        checks++;
        if (wr_led !== 1'b0) begin errors++; $display("FAIL bounce_led_settled: wr_led=%b required 0", wr_led); end
        repeat (12) @(negedge clk);
        checks++;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL bounce_one_write: writes=%0d required 1", wr_cnt - base); end
        release_btn();
    endtask

    task automatic test_wrap();
        int         base;
        logic [7:0] wdat [5];
        logic [7:0] shown [4];
        logic [1:0] a;
        wdat  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        shown = '{8'h55, 8'h22, 8'h33, 8'h44};
        do_reset();
        base = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            press_start(wdat[k]);
            release_btn();
        end
        press_start(wdat[4]);
        for (int k = 0; k < 5; k++) begin
            a = 2'(k % 4);
            checks++;
            if (wr_adr_log[(base + k) % 32] !== a) begin
                errors++;
                $display("FAIL wrap_adr%0d: adr=%0d required %0d", k, wr_adr_log[(base + k) % 32], a);
            end
        end
        for (int k = 0; k < 4; k++) begin
            a = ~2'(k);
            checks++;
            if (adr_led !== a) begin errors++; $display("FAIL wrap_led_start%0d: adr_led=%b required %b", k, adr_led, a); end
            repeat (5) @(negedge clk);
            checks++;
            if (disp_byte !== shown[k]) begin errors++; $display("FAIL wrap_byte%0d: byte=%h required %h", k, disp_byte, shown[k]); end
            repeat (2) @(negedge clk);
            checks++;
            if (adr_led !== a) begin errors++; $display("FAIL wrap_led_end%0d: adr_led=%b required %b", k, adr_led, a); end
            @(negedge clk);
        end
        release_btn();
    endtask

    task automatic test_mismatch();
        do_reset();
        corrupt_en = 1'b1;
        press_start(8'h11);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mismatch_good_first: err=%b required 0", err); end
        release_btn();
        press_start(8'h7E);
        checks++;
        if ({err, disp_byte} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL mismatch_detect: err=%b byte=%h required 1 00", err, disp_byte);
        end
        release_btn();
        press_start(8'h33);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL mismatch_sticky: err=%b required 1", err); end
        release_btn();
        corrupt_en = 1'b0;
        do_reset();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mismatch_reset_clear: err=%b required 0", err); end
    endtask

    task automatic test_busy_drop_and_reset();
        int base;
        int n;
        do_reset();
        base    = wr_cnt;
        data_sw = 8'h5A;
        wr_bttn = 1'b0;
        n = 0;
        while (mem_if.mem_wr !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (mem_if.mem_wr !== 1'b1) begin errors++; $display("FAIL drop_write_seen: mem_wr=%b required 1", mem_if.mem_wr); end
        @(negedge clk);
        force dut.w_press_evt = 1'b1;
        @(negedge clk);
        release dut.w_press_evt;
        repeat (15) @(negedge clk);
        checks++;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL drop_single_write: writes=%0d required 1", wr_cnt - base); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b required 0", busy); end
        release_btn();

        data_sw = 8'hC3;
        wr_bttn = 1'b0;
        n = 0;
        while (mem_if.mem_wr !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_if.mem_wr, busy, adr_led} !== {1'b0, 1'b0, 2'b11}) begin
            errors++;
            $display("FAIL midreset_abort: mem_wr=%b busy=%b adr_led=%b required 0 0 11",
                     mem_if.mem_wr, busy, adr_led);
        end
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        press_start(8'hC3);
        checks++;
        if (wr_cnt !== base + 1) begin errors++; $display("FAIL midreset_rewrite: writes=%0d required 1", wr_cnt - base); end
        checks++;
        if (wr_adr_log[base % 32] !== 2'd0) begin errors++; $display("FAIL midreset_ptr: adr=%0d required 0", wr_adr_log[base % 32]); end
        checks++;
        if ({err, disp_byte} !== {1'b0, 8'hC3}) begin
            errors++;
            $display("FAIL midreset_readback: err=%b byte=%h required 0 c3", err, disp_byte);
        end
        release_btn();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bounce();
        test_wrap();
        test_mismatch();
        test_busy_drop_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
